// File: rtl/jtdsp16_wsel_if.sv
// Register-write bus between the instruction decoder and the write selector.
// The master drives write requests; the slave returns the per-bank strobes and status.
interface jtdsp16_wsel_if;
  logic        cen;
  logic        wr_en;
  logic [2:0]  wsel;
  logic [15:0] wdata;
  logic        pio_ack;
  logic        clr_tout;
  logic        stall;
  logic        we_yaau;
  logic        we_xaau;
  logic        we_dau;
  logic        we_pio;
  logic        we_if;
  logic        w_sub;
  logic [15:0] w_data;
  logic        pio_tout;

  modport master (
    output cen, wr_en, wsel, wdata, pio_ack, clr_tout,
    input  stall, we_yaau, we_xaau, we_dau, we_pio, we_if, w_sub, w_data, pio_tout
  );

  modport slave (
    input  cen, wr_en, wsel, wdata, pio_ack, clr_tout,
    output stall, we_yaau, we_xaau, we_dau, we_pio, we_if, w_sub, w_data, pio_tout
  );
endinterface

// File: rtl/jtdsp16_wsel.sv
// Register write selector: decodes a select/data write into one-hot bank strobes,
// holding PIO writes until the slow peripheral acknowledges or the wait times out.
module jtdsp16_wsel #(
  parameter int PIO_TOUT = 16,
  parameter int CNTW     = 5
) (
  input  logic           clk,
  input  logic           rst,
  jtdsp16_wsel_if.slave  bus
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(PIO_TOUT - 1);

  // Strobe vector bit order: {yaau, xaau, dau, pio, if}
  localparam logic [4:0] STB_YAAU = 5'b10000;
  localparam logic [4:0] STB_XAAU = 5'b01000;
  localparam logic [4:0] STB_DAU  = 5'b00100;
  localparam logic [4:0] STB_PIO  = 5'b00010;
  localparam logic [4:0] STB_IF   = 5'b00001;

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [4:0]      strb_q, strb_d;
  logic            sub_q, sub_d;
  logic [15:0]     data_q, data_d;
  logic            tout_q, tout_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      strb_q  <= '0;
      sub_q   <= 1'b0;
      data_q  <= '0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      strb_q  <= strb_d;
      sub_q   <= sub_d;
      data_q  <= data_d;
      tout_q  <= tout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    strb_d  = strb_q;
    sub_d   = sub_q;
    data_d  = data_q;
    tout_d  = tout_q;
    if (bus.cen) begin
      // Clear first so that a timeout on the same edge sets the flag again
      if (bus.clr_tout) tout_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          strb_d = '0;
          if (bus.wr_en) begin
            sub_d  = bus.wsel[0];
            data_d = bus.wdata;
            case (bus.wsel)
              3'b000, 3'b001: strb_d = STB_YAAU;
              3'b010, 3'b011: strb_d = STB_XAAU;
              3'b100, 3'b101: strb_d = STB_DAU;
              3'b110:         strb_d = STB_IF;
              default: begin
                strb_d  = STB_PIO;
                state_d = ST_WAIT;
                cnt_d   = '0;
              end
            endcase
          end
        end
        default: begin
          if (bus.pio_ack) begin
            state_d = ST_IDLE;
            strb_d  = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_IDLE;
            strb_d  = '0;
            tout_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNTW'(1);
          end
        end
      endcase
    end
  end

  assign bus.stall    = (state_q == ST_WAIT);
  assign bus.we_yaau  = strb_q[4];
  assign bus.we_xaau  = strb_q[3];
  assign bus.we_dau   = strb_q[2];
  assign bus.we_pio   = strb_q[1];
  assign bus.we_if    = strb_q[0];
  assign bus.w_sub    = sub_q;
  assign bus.w_data   = data_q;
  assign bus.pio_tout = tout_q;

endmodule

// File: tb/tb_jtdsp16_wsel.sv
// Directed bench for jtdsp16_wsel: a vector table for single-cycle writes and PIO ack,
// plus hand-written sequences for timeout, cen gating and reset during a PIO wait.
module tb_jtdsp16_wsel;

  typedef struct {
    string       name;
    logic        cen;
    logic        wr;
    logic [2:0]  wsel;
    logic [15:0] data;
    logic        ack;
    logic        clr;
    logic        eStall;
    logic [4:0]  eWe;
    logic        eSub;
    logic [15:0] eData;
    logic        eTout;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  vec_t vecs[$];

  jtdsp16_wsel_if bus ();

  jtdsp16_wsel #(.PIO_TOUT(16), .CNTW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic addVec(input string name, input logic cen, input logic wr,
                        input logic [2:0] wsel, input logic [15:0] data,
                        input logic ack, input logic clr, input logic eStall,
                        input logic [4:0] eWe, input logic eSub,
                        input logic [15:0] eData, input logic eTout);
    vec_t v;
    v.name = name; v.cen = cen; v.wr = wr; v.wsel = wsel; v.data = data;
    v.ack = ack; v.clr = clr; v.eStall = eStall; v.eWe = eWe; v.eSub = eSub;
    v.eData = eData; v.eTout = eTout;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs and return 1 time unit after the rising edge
  task automatic applyStimulus(input logic cen, input logic wr, input logic [2:0] wsel,
                               input logic [15:0] data, input logic ack, input logic clr);
    bus.cen      = cen;
    bus.wr_en    = wr;
    bus.wsel     = wsel;
    bus.wdata    = data;
    bus.pio_ack  = ack;
    bus.clr_tout = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOne(input string name, input string field,
                          input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s.%s: got %h expected %h", name, field, got, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic eStall, input logic [4:0] eWe,
                             input logic eSub, input logic [15:0] eData, input logic eTout);
    logic [4:0] we;
    we = {bus.we_yaau, bus.we_xaau, bus.we_dau, bus.we_pio, bus.we_if};
    checkOne(name, "stall", {15'd0, bus.stall}, {15'd0, eStall});
    checkOne(name, "we", {11'd0, we}, {11'd0, eWe});
    checkOne(name, "w_sub", {15'd0, bus.w_sub}, {15'd0, eSub});
    checkOne(name, "w_data", bus.w_data, eData);
    checkOne(name, "pio_tout", {15'd0, bus.pio_tout}, {15'd0, eTout});
    checks++;
    if ($countones(we) > 1) begin
      errors++;
      $display("[TB] FAIL %s.onehot: got %b expected at most one bit set", name, we);
    end
  endtask

  initial begin
    bus.cen = 1'b0; bus.wr_en = 1'b0; bus.wsel = 3'd0; bus.wdata = 16'h0;
    bus.pio_ack = 1'b0; bus.clr_tout = 1'b0;

    //     name          cen wr wsel    data      ack clr  stall we        sub data      tout
    addVec("t1_xaau",    1, 1, 3'b010, 16'h1234, 0, 0,   0, 5'b01000, 0, 16'h1234, 0);
    addVec("t1_clear",   1, 0, 3'b000, 16'h0000, 0, 0,   0, 5'b00000, 0, 16'h1234, 0);
    addVec("t2_yaau",    1, 1, 3'b000, 16'h0001, 0, 0,   0, 5'b10000, 0, 16'h0001, 0);
    addVec("t2_xaau",    1, 1, 3'b011, 16'h0002, 0, 0,   0, 5'b01000, 1, 16'h0002, 0);
    addVec("t2_dau",     1, 1, 3'b100, 16'h0003, 0, 0,   0, 5'b00100, 0, 16'h0003, 0);
    addVec("t2_if",      1, 1, 3'b110, 16'h0004, 0, 0,   0, 5'b00001, 0, 16'h0004, 0);
    addVec("t2_clear",   1, 0, 3'b000, 16'h0000, 0, 0,   0, 5'b00000, 0, 16'h0004, 0);
    addVec("hold_dau",   1, 1, 3'b101, 16'h0F0F, 0, 0,   0, 5'b00100, 1, 16'h0F0F, 0);
    addVec("hold_cen0",  0, 1, 3'b000, 16'hAAAA, 0, 0,   0, 5'b00100, 1, 16'h0F0F, 0);
    addVec("hold_clear", 1, 0, 3'b000, 16'h0000, 0, 0,   0, 5'b00000, 1, 16'h0F0F, 0);
    addVec("t3_pio",     1, 1, 3'b111, 16'hBEEF, 0, 0,   1, 5'b00010, 1, 16'hBEEF, 0);
    addVec("t3_wait1",   1, 1, 3'b000, 16'h5555, 0, 0,   1, 5'b00010, 1, 16'hBEEF, 0);
    addVec("t3_wait2",   1, 0, 3'b000, 16'h0000, 0, 0,   1, 5'b00010, 1, 16'hBEEF, 0);
    addVec("t3_ack",     1, 0, 3'b000, 16'h0000, 1, 0,   0, 5'b00000, 1, 16'hBEEF, 0);
    addVec("idle_ack",   1, 0, 3'b000, 16'h0000, 1, 0,   0, 5'b00000, 1, 16'hBEEF, 0);

    #3;
    checkOutput("reset", 0, 5'b00000, 0, 16'h0000, 0);
    #4 rst = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].cen, vecs[i].wr, vecs[i].wsel, vecs[i].data, vecs[i].ack, vecs[i].clr);
      checkOutput(vecs[i].name, vecs[i].eStall, vecs[i].eWe, vecs[i].eSub, vecs[i].eData, vecs[i].eTout);
    end

    // Timeout: 16 cen edges in WAIT after the accepting edge, then the sticky flag
    applyStimulus(1, 1, 3'b111, 16'h1111, 0, 0);
    checkOutput("to_accept", 1, 5'b00010, 1, 16'h1111, 0);
    for (int k = 1; k <= 15; k++) begin
      applyStimulus(1, 0, 3'b000, 16'h0000, 0, 0);
      checkOutput($sformatf("to_wait%0d", k), 1, 5'b00010, 1, 16'h1111, 0);
    end
    applyStimulus(1, 0, 3'b000, 16'h0000, 0, 0);
    checkOutput("to_expire", 0, 5'b00000, 1, 16'h1111, 1);
    applyStimulus(1, 0, 3'b000, 16'h0000, 0, 1);
    checkOutput("to_clear", 0, 5'b00000, 1, 16'h1111, 0);

    // cen gating: ack with cen=0 is ignored, counter moves only on cen=1; ack beats timeout
    applyStimulus(1, 1, 3'b111, 16'h00A5, 0, 0);
    checkOutput("cen_accept", 1, 5'b00010, 1, 16'h00A5, 0);
    for (int k = 1; k <= 15; k++) begin
      applyStimulus(0, 0, 3'b000, 16'h0000, 1, 0);
      checkOutput($sformatf("cen0_hold%0d", k), 1, 5'b00010, 1, 16'h00A5, 0);
      applyStimulus(1, 0, 3'b000, 16'h0000, 0, 0);
      checkOutput($sformatf("cen1_step%0d", k), 1, 5'b00010, 1, 16'h00A5, 0);
    end
    applyStimulus(1, 0, 3'b000, 16'h0000, 1, 0);
    checkOutput("ack_beats_tout", 0, 5'b00000, 1, 16'h00A5, 0);

    // Timeout and clr_tout on the same edge: the flag ends up set
    applyStimulus(1, 1, 3'b111, 16'h3333, 0, 0);
    for (int k = 1; k <= 15; k++) applyStimulus(1, 0, 3'b000, 16'h0000, 0, 0);
    checkOutput("set_pre", 1, 5'b00010, 1, 16'h3333, 0);
    applyStimulus(1, 0, 3'b000, 16'h0000, 0, 1);
    checkOutput("set_wins", 0, 5'b00000, 1, 16'h3333, 1);

    // Asynchronous reset on the 2nd WAIT cycle, then a normal write
    applyStimulus(1, 1, 3'b111, 16'h7777, 0, 0);
    applyStimulus(1, 0, 3'b000, 16'h0000, 0, 0);
    checkOutput("rst_pre", 1, 5'b00010, 1, 16'h7777, 1);
    #2 rst = 1'b1;
    #1 checkOutput("rst_async", 0, 5'b00000, 0, 16'h0000, 0);
    #1 rst = 1'b0;
    applyStimulus(1, 1, 3'b011, 16'h2222, 0, 0);
    checkOutput("rst_after", 0, 5'b01000, 1, 16'h2222, 0);
    applyStimulus(1, 0, 3'b000, 16'h0000, 0, 0);
    checkOutput("rst_after_clr", 0, 5'b00000, 1, 16'h2222, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
